// File: rtl/apb2axi_cpl_tracker.sv
// Per-tag completion status table fed from the completion FIFO, with clear-on-read lookups and tag return.
// Pop, lookup, clear and tag return all land 1 cycle later; the only pop stall is a same-tag lookup in the same cycle.
module apb2axi_cpl_tracker #(
   parameter int TAG_NUM = 16,
   parameter int TAG_W   = $clog2(TAG_NUM),
   parameter int CPL_W   = 1 + TAG_W + 2 + 1 + 8
) (
   input  logic               pclk,
   input  logic               presetn,
   input  logic               cq_pop_vld,
   input  logic [CPL_W-1:0]   cq_pop_data,
   output logic               cq_pop_rdy,
   input  logic               st_rd_en,
   input  logic [TAG_W-1:0]   st_rd_tag,
   output logic               st_rd_vld,
   output logic [15:0]        st_rd_data,
   output logic               tag_free_vld,
   output logic [TAG_W-1:0]   tag_free_tag,
   input  logic               tag_free_rdy,
   input  logic               irq_en,
   output logic               irq,
   output logic [TAG_NUM-1:0] done_vec,
   output logic [15:0]        err_cnt,
   output logic               dup_err
);

   typedef struct packed {
      logic             is_write;
      logic [TAG_W-1:0] tag;
      logic [1:0]       resp;
      logic             error;
      logic [7:0]       num_beats;
   } cpl_t;

   typedef struct packed {
      logic       is_write;
      logic [1:0] resp;
      logic       error;
      logic [7:0] num_beats;
   } stat_t;

   cpl_t               cpl;
   stat_t              tbl_q [TAG_NUM];
   logic [TAG_NUM-1:0] done_q;
   stat_t              rd_sel;
   logic               rd_hit;
   logic               free_avail;
   logic               clr;
   logic               busy;
   logic               pop_fire;
   logic               pop_dup;

   assign cpl = cq_pop_data;

   // A lookup of the tag being popped would race the clear, so the pop waits a cycle.
   assign cq_pop_rdy = !(cq_pop_vld && st_rd_en && (st_rd_tag == cpl.tag));
   assign pop_fire   = cq_pop_vld && cq_pop_rdy;
   assign pop_dup    = done_q[cpl.tag];

   assign rd_sel     = tbl_q[st_rd_tag];
   assign rd_hit     = done_q[st_rd_tag];
   assign free_avail = !tag_free_vld || tag_free_rdy;
   assign clr        = st_rd_en && rd_hit && free_avail;
   assign busy       = st_rd_en && rd_hit && !free_avail;

   assign done_vec   = done_q;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         done_q <= '0;
         for (int i = 0; i < TAG_NUM; i++) begin
            tbl_q[i] <= '0;
         end
      end else begin
         // Pop and clear never target the same tag: the collision stall above guarantees it.
         if (clr) begin
            done_q[st_rd_tag] <= 1'b0;
         end
         if (pop_fire && !pop_dup) begin
            done_q[cpl.tag]          <= 1'b1;
            tbl_q[cpl.tag].is_write  <= cpl.is_write;
            tbl_q[cpl.tag].resp      <= cpl.resp;
            tbl_q[cpl.tag].error     <= cpl.error;
            tbl_q[cpl.tag].num_beats <= cpl.num_beats;
         end
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         st_rd_vld  <= 1'b0;
         st_rd_data <= '0;
      end else begin
         st_rd_vld <= st_rd_en;
         if (st_rd_en) begin
            st_rd_data <= {rd_hit, rd_sel.is_write, rd_sel.resp, rd_sel.error,
                           busy, 2'b00, rd_sel.num_beats};
         end
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         tag_free_vld <= 1'b0;
         tag_free_tag <= '0;
      end else begin
         if (clr) begin
            tag_free_vld <= 1'b1;
            tag_free_tag <= st_rd_tag;
         end else if (tag_free_rdy) begin
            tag_free_vld <= 1'b0;
         end
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         irq     <= 1'b0;
         err_cnt <= '0;
         dup_err <= 1'b0;
      end else begin
         irq <= irq_en && (|done_q);
         // Duplicates still count toward the error total.
         if (pop_fire && cpl.error && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
         end
         if (pop_fire && pop_dup) begin
            dup_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_apb2axi_cpl_tracker.sv
// Bench for apb2axi_cpl_tracker: directed scenarios then random traffic against a per-tag table model.
module tb_apb2axi_cpl_tracker;
   localparam int TAG_NUM = 16;
   localparam int TAG_W   = 4;
   localparam int CPL_W   = 16;

   logic               pclk = 1'b0;
   logic               presetn;
   logic               cq_pop_vld;
   logic [CPL_W-1:0]   cq_pop_data;
   logic               cq_pop_rdy;
   logic               st_rd_en;
   logic [TAG_W-1:0]   st_rd_tag;
   logic               st_rd_vld;
   logic [15:0]        st_rd_data;
   logic               tag_free_vld;
   logic [TAG_W-1:0]   tag_free_tag;
   logic               tag_free_rdy;
   logic               irq_en;
   logic               irq;
   logic [TAG_NUM-1:0] done_vec;
   logic [15:0]        err_cnt;
   logic               dup_err;

   always #5 pclk = ~pclk;

   apb2axi_cpl_tracker #(.TAG_NUM(TAG_NUM), .TAG_W(TAG_W), .CPL_W(CPL_W)) dut (
      .pclk(pclk), .presetn(presetn),
      .cq_pop_vld(cq_pop_vld), .cq_pop_data(cq_pop_data), .cq_pop_rdy(cq_pop_rdy),
      .st_rd_en(st_rd_en), .st_rd_tag(st_rd_tag), .st_rd_vld(st_rd_vld), .st_rd_data(st_rd_data),
      .tag_free_vld(tag_free_vld), .tag_free_tag(tag_free_tag), .tag_free_rdy(tag_free_rdy),
      .irq_en(irq_en), .irq(irq), .done_vec(done_vec), .err_cnt(err_cnt), .dup_err(dup_err)
   );

   typedef struct {
      bit       done;
      bit       wr;
      bit [1:0] resp;
      bit       err;
      bit [7:0] beats;
   } ent_t;

   ent_t        tbl [TAG_NUM];
   bit          m_fvld;
   int          m_ftag;
   bit          m_irq;
   int          m_ecnt;
   bit          m_dup;
   bit          m_rvld;
   logic [15:0] m_rdat;
   int          total = 0;
   int          bad = 0;
   logic [15:0] q[$];
   bit          f;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] mk(int w, int t, int r, int e, int b);
      return {w[0], t[3:0], r[1:0], e[0], b[7:0]};
   endfunction

   task automatic model_reset();
      foreach (tbl[i]) tbl[i] = '{0, 0, 2'b00, 0, 8'h00};
      m_fvld = 0; m_ftag = 0; m_irq = 0; m_ecnt = 0; m_dup = 0; m_rvld = 0; m_rdat = '0;
   endtask

   task automatic check_zero(string pfx);
      bit exp_rdy;
      exp_rdy = !(cq_pop_vld && st_rd_en && (st_rd_tag == cq_pop_data[14:11]));
      chk({pfx, "_pop_rdy"}, 32'(cq_pop_rdy), 32'(exp_rdy));
      chk({pfx, "_rd_vld"}, 32'(st_rd_vld), 32'd0);
      chk({pfx, "_rd_data"}, 32'(st_rd_data), 32'd0);
      chk({pfx, "_free_vld"}, 32'(tag_free_vld), 32'd0);
      chk({pfx, "_free_tag"}, 32'(tag_free_tag), 32'd0);
      chk({pfx, "_irq"}, 32'(irq), 32'd0);
      chk({pfx, "_done_vec"}, 32'(done_vec), 32'd0);
      chk({pfx, "_err_cnt"}, 32'(err_cnt), 32'd0);
      chk({pfx, "_dup_err"}, 32'(dup_err), 32'd0);
   endtask

   // One clock: predict from pre-edge state and inputs, advance the model, then compare after the edge.
   task automatic step(output bit fired);
      bit                 exp_rdy, clr, busy, pre_done, any_done;
      int                 pt, rt;
      ent_t               e;
      logic [15:0]        d;
      logic [TAG_NUM-1:0] exp_vec;
      @(negedge pclk);
      d  = cq_pop_data;
      pt = int'(d[14:11]);
      rt = int'(st_rd_tag);
      exp_rdy = !(cq_pop_vld && st_rd_en && pt == rt);
      chk("pop_rdy", 32'(cq_pop_rdy), 32'(exp_rdy));
      fired = cq_pop_vld && exp_rdy;
      any_done = 0;
      foreach (tbl[i]) any_done |= tbl[i].done;
      clr = 0;
      if (st_rd_en) begin
         e    = tbl[rt];
         busy = e.done && m_fvld && !tag_free_rdy;
         clr  = e.done && !busy;
         m_rdat = {e.done, e.wr, e.resp, e.err, busy, 2'b00, e.beats};
      end
      m_rvld   = st_rd_en;
      pre_done = tbl[pt].done;
      @(posedge pclk);
      m_irq = irq_en && any_done;
      if (m_fvld && tag_free_rdy) m_fvld = 0;
      if (clr) begin
         tbl[rt].done = 0;
         m_fvld = 1;
         m_ftag = rt;
      end
      if (fired) begin
         if (pre_done) m_dup = 1;
         else tbl[pt] = '{1'b1, d[15], d[10:9], d[8], d[7:0]};
         if (d[8] && m_ecnt < 65535) m_ecnt++;
      end
      #1;
      for (int i = 0; i < TAG_NUM; i++) exp_vec[i] = tbl[i].done;
      chk("done_vec", 32'(done_vec), 32'(exp_vec));
      chk("rd_vld", 32'(st_rd_vld), 32'(m_rvld));
      if (m_rvld) chk("rd_data", 32'(st_rd_data), 32'(m_rdat));
      chk("free_vld", 32'(tag_free_vld), 32'(m_fvld));
      if (m_fvld) chk("free_tag", 32'(tag_free_tag), 32'(m_ftag));
      chk("irq", 32'(irq), 32'(m_irq));
      chk("err_cnt", 32'(err_cnt), 32'(m_ecnt));
      chk("dup_err", 32'(dup_err), 32'(m_dup));
   endtask

   task automatic drive(bit v, logic [15:0] d, bit en, int t, bit fr);
      cq_pop_vld   = v;
      cq_pop_data  = d;
      st_rd_en     = en;
      st_rd_tag    = t[3:0];
      tag_free_rdy = fr;
   endtask

   task automatic do_reset(string pfx);
      #2 presetn = 1'b0;
      #1 check_zero(pfx);
      model_reset();
      q.delete();
      drive(0, 16'h0, 0, 0, 1);
      @(posedge pclk);
      #1 presetn = 1'b1;
   endtask

   initial begin
      presetn = 1'b0;
      irq_en  = 1'b1;
      drive(0, 16'h0, 0, 0, 1);
      model_reset();
      #12 check_zero("rst");
      @(posedge pclk);
      #1 presetn = 1'b1;

      // read completion, lookup clears and returns the tag
      drive(1, mk(0, 3, 0, 0, 4), 0, 0, 1); step(f);
      chk("rd_done3", 32'(done_vec[3]), 32'd1);
      drive(0, 16'h0, 1, 3, 1); step(f);
      chk("rd_data3", 32'(st_rd_data), 32'h8004);
      chk("rd_free3", 32'({tag_free_vld, tag_free_tag}), 32'h13);
      chk("rd_clr3", 32'(done_vec[3]), 32'd0);

      // write with error
      drive(1, mk(1, 5, 2, 1, 0), 0, 0, 1); step(f);
      chk("we_cnt", 32'(err_cnt), 32'd1);
      drive(0, 16'h0, 0, 0, 1); step(f);
      chk("we_irq", 32'(irq), 32'd1);
      drive(0, 16'h0, 1, 5, 1); step(f);
      chk("we_data5", 32'(st_rd_data), 32'hE800);

      // same-tag collision stalls the pop for one cycle
      drive(1, mk(0, 2, 0, 0, 1), 1, 2, 1); step(f);
      chk("col_fire", 32'(f), 32'd0);
      chk("col_done", 32'(st_rd_data[15]), 32'd0);
      drive(1, mk(0, 2, 0, 0, 1), 0, 0, 1); step(f);
      chk("col_fire2", 32'(f), 32'd1);
      chk("col_done2", 32'(done_vec[2]), 32'd1);

      // free register backpressure
      drive(1, mk(0, 1, 0, 0, 2), 0, 0, 0); step(f);
      drive(1, mk(0, 4, 0, 0, 3), 0, 0, 0); step(f);
      drive(0, 16'h0, 1, 1, 0); step(f);
      chk("bp_free1", 32'({tag_free_vld, tag_free_tag}), 32'h11);
      drive(0, 16'h0, 1, 4, 0); step(f);
      chk("bp_busy", 32'(st_rd_data[10]), 32'd1);
      chk("bp_keep4", 32'(done_vec[4]), 32'd1);
      drive(0, 16'h0, 1, 4, 1); step(f);
      chk("bp_clr4", 32'(done_vec[4]), 32'd0);
      chk("bp_free4", 32'({tag_free_vld, tag_free_tag}), 32'h14);

      // duplicate completion keeps the first entry
      drive(1, mk(0, 7, 0, 0, 8), 0, 0, 1); step(f);
      drive(1, mk(1, 7, 3, 1, 9), 0, 0, 1); step(f);
      chk("dup_fire", 32'(f), 32'd1);
      chk("dup_flag", 32'(dup_err), 32'd1);
      drive(0, 16'h0, 1, 7, 1); step(f);
      chk("dup_data7", 32'(st_rd_data), 32'h8008);

      // random traffic with one mid-stream reset
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) do_reset("mid");
         if (q.size() < 6 && $urandom_range(0, 2) == 0)
            q.push_back(mk(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                           int'($urandom_range(0, 3)), int'($urandom_range(0, 3) == 0),
                           int'($urandom_range(0, 255))));
         cq_pop_vld   = q.size() > 0;
         cq_pop_data  = (q.size() > 0) ? q[0] : 16'h0;
         st_rd_en     = $urandom_range(0, 2) == 0;
         st_rd_tag    = ($urandom_range(0, 3) == 0 && q.size() > 0) ? q[0][14:11]
                                                                   : 4'($urandom_range(0, 15));
         tag_free_rdy = $urandom_range(0, 1) == 1;
         irq_en       = $urandom_range(0, 7) != 0;
         step(f);
         if (f) void'(q.pop_front());
      end

      // drive the error counter into saturation
      irq_en = 1'b1;
      for (int c = 0; c < 65600; c++) begin
         drive(1, mk(c % 2, c % 16, 2, 1, c % 256), 0, 0, 1);
         step(f);
      end
      chk("sat_cnt", 32'(err_cnt), 32'hFFFF);
      do_reset("end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/apb2axi_cpl_tracker.md
# apb2axi_cpl_tracker

Per-tag completion status tracker on the APB side of the bridge. Pops completion entries (reads and writes) from the pop side of the completion FIFO, records them in a per-tag status table, and serves status lookups for the APB register file. A status read of a completed tag clears it and returns the tag to the tag allocator. Also drives a level interrupt and a saturating error counter.

## Interface
- TAG_NUM, 16, number of outstanding-transaction tags
- TAG_W, 4, tag width, $clog2(TAG_NUM)
- CPL_W, 16, completion entry width = 1+TAG_W+2+1+8
- pclk  in  1  APB-side clock; one clock, all logic on rising edge
- presetn  in  1  asynchronous active-low reset
- cq_pop_vld  in  1  completion FIFO has an entry
- cq_pop_data  in  CPL_W  entry, MSB-first {is_write, tag[TAG_W-1:0], resp[1:0], error, num_beats[7:0]}
- cq_pop_rdy  out  1  pop strobe; entry consumed when cq_pop_vld && cq_pop_rdy
- st_rd_en  in  1  status lookup request (1-cycle pulse from register file)
- st_rd_tag  in  TAG_W  tag being looked up
- st_rd_vld  out  1  status word valid, exactly 1 cycle after st_rd_en
- st_rd_data  out  16  {done, is_write, resp[1:0], error, busy, 2'b00, num_beats[7:0]}
- tag_free_vld  out  1  tag return request to allocator
- tag_free_tag  out  TAG_W  tag being returned
- tag_free_rdy  in  1  allocator accepts tag
- irq_en  in  1  interrupt enable
- irq  out  1  registered level interrupt
- done_vec  out  TAG_NUM  per-tag done bits
- err_cnt  out  16  saturating count of completions with error=1
- dup_err  out  1  sticky: completion arrived for an already-done tag

## Operation
- Status table per tag: done, is_write, resp, error, num_beats. All cleared on reset.
- Pop: cq_pop_rdy = !(cq_pop_vld && st_rd_en && st_rd_tag == cq_pop_data.tag). This is the only stall condition. It is combinational.
- On a pop handshake for tag T:
  - If done[T]=0: write the fields and set done[T]=1.
  - If done[T]=1: keep the old entry, set dup_err=1 (sticky until reset), and still consume the entry.
- err_cnt increments on every popped entry with error=1, including duplicates. It saturates at 16'hFFFF.
- Lookup on st_rd_en for tag T: next cycle st_rd_vld=1 and st_rd_data shows the pre-clear table contents of T.
  - Case done[T]=1 and the free register is available (tag_free_vld=0, or tag_free_rdy=1 this cycle): clear done[T], load tag_free_tag=T, set tag_free_vld=1. busy=0.
  - Case done[T]=1 and the free register is occupied and not draining: no clear, busy=1. Software retries.
  - Case done[T]=0: return done=0 and the stale fields, with busy=0. No clear.
- Free register: single entry. tag_free_vld stays high until tag_free_rdy. tag_free_tag is stable while tag_free_vld is high.
- Same-cycle pop of tag A and clear of tag B (A≠B): both take effect.
- irq <= irq_en && |done_vec (registered from the current done_vec).

## Timing
- Reset values (async assert): cq_pop_rdy combinational per the rule above; all of the following are 0: st_rd_vld, st_rd_data, tag_free_vld, tag_free_tag, irq, done_vec, err_cnt, dup_err.
- Pop to done_vec[T]=1: 1 cycle. Pop to irq: 2 cycles.
- st_rd_en to st_rd_vld/st_rd_data: 1 cycle. st_rd_vld is a 1-cycle pulse.
- Clear to done_vec[T]=0 and tag_free_vld=1: 1 cycle after st_rd_en, in the same cycle as st_rd_vld.
- Back-to-back pops: one per cycle. Back-to-back lookups: one per cycle.
- Reset mid-operation: the table, the free register and the counters are dropped. The allocator is reset by the same presetn.

## Test plan
- Read completion: pop {0,tag 3,OKAY,0,beats 4}; then st_rd_en tag 3 -> done_vec[3]=1 after 1 cycle; st_rd_data=16'h8004; tag_free_vld=1 with tag_free_tag=3; done_vec[3]=0.
- Write error completion: pop {1,tag 5,SLVERR,1,0} -> err_cnt=1, irq=1 with irq_en=1; lookup tag 5 returns 16'hE800.
- Collision: cq_pop_vld for tag 2 while st_rd_en tag 2 -> cq_pop_rdy=0 that cycle; lookup returns done=0; pop completes the next cycle.
- Free backpressure: tag_free_rdy=0, complete tags 1 and 4; lookup 1 (clears), lookup 4 -> busy=1, done_vec[4] stays 1. Raise tag_free_rdy, retry 4 -> clears.
- Duplicate: pop tag 7 twice without a lookup -> dup_err=1; the second entry is consumed and the table keeps the first entry's fields.
- Saturation and reset: force err_cnt to FFFF via popped error entries -> holds at FFFF; assert presetn low mid-stream -> all outputs 0 asynchronously.
